// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results and in-order loads into the register file.
// Define WB_FWD_EN to mirror the register-file write port onto the fwd_* bypass outputs.
module wb_stage (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        ex_wb_en_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [31:0] ex_result_i,
    input  logic        ex_is_load_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [1:0]  ex_offset_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        rf_write_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        ld_pend_o,
    output logic [4:0]  ld_rd_o,
    output logic        load_err_o,
    output logic        fwd_valid_o,
    output logic [4:0]  fwd_rd_o,
    output logic [31:0] fwd_data_o
);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t      state_q, state_d;
    logic [4:0]  ld_rd_q;
    logic        ld_wb_en_q;
    logic        ld_err_q;
    logic [2:0]  ld_funct3_q;
    logic [1:0]  ld_offset_q;
    logic        accept;
    logic        load_bad;
    logic        wr_d;
    logic        err_d;
    logic [4:0]  waddr_d;
    logic [31:0] wdata_d;

    // Selects the addressed byte/halfword of the aligned word and extends it.
    function automatic logic [31:0] extract(input logic [2:0]  funct3,
                                            input logic [1:0]  offset,
                                            input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (offset)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'b0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'b0, h};
            default: extract = rdata;
        endcase
    endfunction

    assign ex_ready_o = (state_q == IDLE);
    assign accept     = ex_valid_i && ex_ready_o;
    assign ld_pend_o  = (state_q == LOAD_WAIT);
    assign ld_rd_o    = ld_rd_q;

    always_comb begin
        load_bad = 1'b1;
        case (ex_funct3_i)
            3'b000, 3'b100: load_bad = 1'b0;
            3'b001, 3'b101: load_bad = ex_offset_i[0];
            3'b010:         load_bad = (ex_offset_i != 2'd0);
            default:        load_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write port defaults to holding its last address/data; only a retire updates it.
    always_comb begin
        state_d = state_q;
        wr_d    = 1'b0;
        err_d   = 1'b0;
        waddr_d = rf_waddr_o;
        wdata_d = rf_wdata_o;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ex_is_load_i) begin
                        state_d = LOAD_WAIT;
                    end else if (ex_wb_en_i && (ex_rd_i != 5'd0)) begin
                        wr_d    = 1'b1;
                        waddr_d = ex_rd_i;
                        wdata_d = ex_result_i;
                    end
                end
            end
            LOAD_WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                    if (ld_err_q) begin
                        err_d = 1'b1;
                    end else if (ld_wb_en_q && (ld_rd_q != 5'd0)) begin
                        wr_d    = 1'b1;
                        waddr_d = ld_rd_q;
                        wdata_d = extract(ld_funct3_q, ld_offset_q, dmem_rdata_i);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_rd_q     <= 5'd0;
            ld_wb_en_q  <= 1'b0;
            ld_err_q    <= 1'b0;
            ld_funct3_q <= 3'd0;
            ld_offset_q <= 2'd0;
        end else if (accept && ex_is_load_i) begin
            ld_rd_q     <= ex_rd_i;
            ld_wb_en_q  <= ex_wb_en_i;
            ld_err_q    <= load_bad;
            ld_funct3_q <= ex_funct3_i;
            ld_offset_q <= ex_offset_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_write_o <= 1'b0;
            rf_waddr_o <= 5'd0;
            rf_wdata_o <= 32'd0;
            load_err_o <= 1'b0;
        end else begin
            rf_write_o <= wr_d;
            rf_waddr_o <= waddr_d;
            rf_wdata_o <= wdata_d;
            load_err_o <= err_d;
        end
    end

`ifdef WB_FWD_EN
    // Covers the register file's write-then-read cycle for the consumer.
    assign fwd_valid_o = rf_write_o;
    assign fwd_rd_o    = rf_waddr_o;
    assign fwd_data_o  = rf_wdata_o;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_rd_o    = 5'd0;
    assign fwd_data_o  = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table-driven ALU and load vectors with a write scoreboard.
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic        ex_wb_en_i = 1'b0;
    logic [4:0]  ex_rd_i = 5'd0;
    logic [31:0] ex_result_i = 32'd0;
    logic        ex_is_load_i = 1'b0;
    logic [2:0]  ex_funct3_i = 3'd0;
    logic [1:0]  ex_offset_i = 2'd0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = 32'd0;
    logic        rf_write_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        ld_pend_o;
    logic [4:0]  ld_rd_o;
    logic        load_err_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    wb_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_wb_en_i(ex_wb_en_i), .ex_rd_i(ex_rd_i), .ex_result_i(ex_result_i),
        .ex_is_load_i(ex_is_load_i), .ex_funct3_i(ex_funct3_i), .ex_offset_i(ex_offset_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .rf_write_o(rf_write_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .ld_pend_o(ld_pend_o), .ld_rd_o(ld_rd_o), .load_err_o(load_err_o),
        .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        is_err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        valid;
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        exp_write;
    } alu_vec_t;

    typedef struct {
        logic [2:0]  funct3;
        logic [1:0]  offset;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          waits;
        logic        exp_err;
        logic        exp_write;
        logic [31:0] exp_data;
    } ld_vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [4:0]  last_waddr = 5'd0;
    logic [31:0] last_wdata = 32'd0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic wb, input logic [4:0] rd,
                                 input logic [31:0] res, input logic ld,
                                 input logic [2:0] f3, input logic [1:0] off);
        ex_valid_i   = v;
        ex_wb_en_i   = wb;
        ex_rd_i      = rd;
        ex_result_i  = res;
        ex_is_load_i = ld;
        ex_funct3_i  = f3;
        ex_offset_i  = off;
    endtask

    task automatic pushExp(input logic [4:0] a, input logic [31:0] d, input logic err);
        exp_t e;
        e.waddr  = a;
        e.wdata  = d;
        e.is_err = err;
        e.cyc    = cyc + 1;
        sb.push_back(e);
        if (!err) begin
            last_waddr = a;
            last_wdata = d;
        end
    endtask

    // Every write or error pulse must match the oldest expectation in the exact cycle.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (rf_write_o || load_err_o) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_event", {30'd0, load_err_o, rf_write_o}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("sb_write", 32'(rf_write_o), 32'(!mon_e.is_err));
                    checkOutput("sb_err", 32'(load_err_o), 32'(mon_e.is_err));
                    checkOutput("sb_cycle", 32'(cyc), 32'(mon_e.cyc));
                    if (!mon_e.is_err) begin
                        checkOutput("sb_waddr", 32'(rf_waddr_o), 32'(mon_e.waddr));
                        checkOutput("sb_wdata", rf_wdata_o, mon_e.wdata);
                        checkOutput("fwd_valid", 32'(fwd_valid_o), 32'(FWD));
                        checkOutput("fwd_rd", 32'(fwd_rd_o), FWD ? 32'(mon_e.waddr) : 32'd0);
                        checkOutput("fwd_data", fwd_data_o, FWD ? mon_e.wdata : 32'd0);
                    end
                end
            end else begin
                checkOutput("fwd_valid_idle", 32'(fwd_valid_o), 32'd0);
            end
        end
    end

    task automatic runLoad(input ld_vec_t v);
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b1, v.rd, 32'hCAFE0000, 1'b1, v.funct3, v.offset);
        checkOutput("ld_accept_ready", 32'(ex_ready_o), 32'd1);
        for (int k = 0; k <= v.waits; k++) begin
            @(negedge clk_i);
            applyStimulus(1'b1, 1'b1, 5'd9, 32'h99999999, 1'b0, 3'd0, 2'd0);
            checkOutput("ld_pend", 32'(ld_pend_o), 32'd1);
            checkOutput("ld_ready_low", 32'(ex_ready_o), 32'd0);
            checkOutput("ld_rd", 32'(ld_rd_o), 32'(v.rd));
            dmem_rvalid_i = (k == v.waits);
            dmem_rdata_i  = (k == v.waits) ? v.rdata : $urandom;
            if (k == v.waits && (v.exp_err || v.exp_write))
                pushExp(v.rd, v.exp_data, v.exp_err);
        end
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
        checkOutput("ld_done_ready", 32'(ex_ready_o), 32'd1);
        checkOutput("ld_done_pend", 32'(ld_pend_o), 32'd0);
    endtask

    alu_vec_t alu_tbl[9];
    ld_vec_t  ld_tbl[14];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        alu_tbl[0] = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
        alu_tbl[1] = '{1'b1, 1'b1, 5'd0,  32'h00000001, 1'b0};
        alu_tbl[2] = '{1'b1, 1'b0, 5'd6,  32'h12345678, 1'b0};
        alu_tbl[3] = '{1'b1, 1'b1, 5'd1,  32'h11111111, 1'b1};
        alu_tbl[4] = '{1'b1, 1'b1, 5'd2,  32'h22222222, 1'b1};
        alu_tbl[5] = '{1'b1, 1'b1, 5'd3,  32'h33333333, 1'b1};
        alu_tbl[6] = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
        alu_tbl[7] = '{1'b0, 1'b1, 5'd4,  32'h44444444, 1'b0};
        alu_tbl[8] = '{1'b1, 1'b1, 5'd4,  32'h55555555, 1'b1};

        ld_tbl[0]  = '{3'b000, 2'd2, 5'd10, 32'h00800000, 3, 1'b0, 1'b1, 32'hFFFFFF80};
        ld_tbl[1]  = '{3'b100, 2'd2, 5'd11, 32'h00800000, 3, 1'b0, 1'b1, 32'h00000080};
        ld_tbl[2]  = '{3'b001, 2'd1, 5'd12, 32'h12345678, 1, 1'b1, 1'b0, 32'h0};
        ld_tbl[3]  = '{3'b101, 2'd2, 5'd13, 32'hABCD1234, 0, 1'b0, 1'b1, 32'h0000ABCD};
        ld_tbl[4]  = '{3'b001, 2'd2, 5'd14, 32'h80011234, 2, 1'b0, 1'b1, 32'hFFFF8001};
        ld_tbl[5]  = '{3'b010, 2'd0, 5'd15, 32'h12345678, 0, 1'b0, 1'b1, 32'h12345678};
        ld_tbl[6]  = '{3'b010, 2'd2, 5'd16, 32'h12345678, 1, 1'b1, 1'b0, 32'h0};
        ld_tbl[7]  = '{3'b011, 2'd0, 5'd17, 32'h12345678, 0, 1'b1, 1'b0, 32'h0};
        ld_tbl[8]  = '{3'b000, 2'd3, 5'd18, 32'h7F000000, 0, 1'b0, 1'b1, 32'h0000007F};
        ld_tbl[9]  = '{3'b100, 2'd0, 5'd19, 32'hAABBCCF0, 1, 1'b0, 1'b1, 32'h000000F0};
        ld_tbl[10] = '{3'b101, 2'd0, 5'd20, 32'hAABBCCF0, 0, 1'b0, 1'b1, 32'h0000CCF0};
        ld_tbl[11] = '{3'b110, 2'd0, 5'd21, 32'h12345678, 0, 1'b1, 1'b0, 32'h0};
        ld_tbl[12] = '{3'b111, 2'd0, 5'd22, 32'h12345678, 0, 1'b1, 1'b0, 32'h0};
        ld_tbl[13] = '{3'b010, 2'd0, 5'd0,  32'h87654321, 1, 1'b0, 1'b0, 32'h0};

        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("rst_ready", 32'(ex_ready_o), 32'd1);
        checkOutput("rst_write", 32'(rf_write_o), 32'd0);
        checkOutput("rst_waddr", 32'(rf_waddr_o), 32'd0);
        checkOutput("rst_wdata", rf_wdata_o, 32'd0);
        checkOutput("rst_pend", 32'(ld_pend_o), 32'd0);
        checkOutput("rst_ld_rd", 32'(ld_rd_o), 32'd0);
        checkOutput("rst_err", 32'(load_err_o), 32'd0);
        checkOutput("rst_fwd", {26'd0, fwd_valid_o, fwd_rd_o}, 32'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk_i);
            applyStimulus(alu_tbl[i].valid, alu_tbl[i].wb_en, alu_tbl[i].rd,
                          alu_tbl[i].result, 1'b0, 3'd0, 2'd0);
            checkOutput("alu_ready", 32'(ex_ready_o), 32'd1);
            if (alu_tbl[i].exp_write) pushExp(alu_tbl[i].rd, alu_tbl[i].result, 1'b0);
        end
        @(negedge clk_i);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);

        for (int i = 0; i < 14; i++) runLoad(ld_tbl[i]);

        $display("[TB] rvalid while idle");
        @(negedge clk_i);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFFFFFF;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        checkOutput("idle_rv_write", 32'(rf_write_o), 32'd0);
        checkOutput("idle_rv_err", 32'(load_err_o), 32'd0);
        checkOutput("idle_rv_waddr", 32'(rf_waddr_o), 32'(last_waddr));
        checkOutput("idle_rv_wdata", rf_wdata_o, last_wdata);
        checkOutput("idle_rv_ready", 32'(ex_ready_o), 32'd1);

        $display("[TB] reset during load wait");
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b1, 5'd12, 32'd0, 1'b1, 3'b010, 2'd0);
        @(negedge clk_i);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
        checkOutput("mid_pend", 32'(ld_pend_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("async_rst_pend", 32'(ld_pend_o), 32'd0);
        checkOutput("async_rst_ready", 32'(ex_ready_o), 32'd1);
        checkOutput("async_rst_waddr", 32'(rf_waddr_o), 32'd0);
        checkOutput("async_rst_wdata", rf_wdata_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h5A5A5A5A;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        checkOutput("post_rst_write", 32'(rf_write_o), 32'd0);
        checkOutput("post_rst_waddr", 32'(rf_waddr_o), 32'd0);
        checkOutput("post_rst_wdata", rf_wdata_o, 32'd0);
        checkOutput("post_rst_pend", 32'(ld_pend_o), 32'd0);
        checkOutput("post_rst_ld_rd", 32'(ld_rd_o), 32'd0);
        checkOutput("post_rst_err", 32'(load_err_o), 32'd0);
        checkOutput("post_rst_ready", 32'(ex_ready_o), 32'd1);

        repeat (3) @(negedge clk_i);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
